// File: rtl/bin_oh_codec.sv
// Registered binary<->one-hot converter feeding a 2-deep in-order output FIFO.
// Each transaction picks its own direction; malformed codes are flagged and counted.
module bin_oh_codec #(
  parameter int Bin_w = 4,
  parameter int O_w   = 2**Bin_w,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [O_w-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [O_w-1:0]   out_data,
  output logic             out_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_e;

  fill_e            count_q, count_d;
  logic [O_w-1:0]   headData_q, headData_d;
  logic [O_w-1:0]   tailData_q, tailData_d;
  logic             headErr_q, headErr_d;
  logic             tailErr_q, tailErr_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;

  logic             push, pop, errPush;
  logic             b2oRange;
  logic [O_w-1:0]   b2oData;
  logic             o2bSeen, o2bMulti, o2bErr;
  logic [Bin_w-1:0] o2bIdx;
  logic [O_w-1:0]   o2bData;
  logic [O_w-1:0]   convData;
  logic             convErr;

  // Any set bit above the binary field makes a binary operand out of range.
  generate
    if (O_w > Bin_w) begin : gRangeChk
      assign b2oRange = |in_data[O_w-1:Bin_w];
    end else begin : gNoRangeChk
      assign b2oRange = 1'b0;
    end
  endgenerate

  always_comb begin
    b2oData = '0;
    if (!b2oRange) begin
      b2oData = O_w'(1) << in_data[Bin_w-1:0];
    end
  end

  // Exact one-hot check: zero or multiple set bits are errors, no priority pick.
  always_comb begin
    o2bSeen  = 1'b0;
    o2bMulti = 1'b0;
    o2bIdx   = '0;
    for (int k = 0; k < O_w; k++) begin
      if (in_data[k]) begin
        if (o2bSeen) begin
          o2bMulti = 1'b1;
        end
        o2bSeen = 1'b1;
        o2bIdx  = Bin_w'(k);
      end
    end
    o2bErr  = !o2bSeen || o2bMulti;
    o2bData = o2bErr ? '0 : O_w'(o2bIdx);
  end

  assign convData = in_mode ? o2bData : b2oData;
  assign convErr  = in_mode ? o2bErr  : b2oRange;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign errPush   = push && convErr;

  // Head slot is cleared whenever it empties so the outputs read zero when idle.
  always_comb begin
    count_d    = count_q;
    headData_d = headData_q;
    headErr_d  = headErr_q;
    tailData_d = tailData_q;
    tailErr_d  = tailErr_q;
    case (count_q)
      EMPTY: begin
        if (push) begin
          headData_d = convData;
          headErr_d  = convErr;
          count_d    = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          headData_d = convData;
          headErr_d  = convErr;
        end else if (push) begin
          tailData_d = convData;
          tailErr_d  = convErr;
          count_d    = FULL;
        end else if (pop) begin
          headData_d = '0;
          headErr_d  = 1'b0;
          count_d    = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          headData_d = tailData_q;
          headErr_d  = tailErr_q;
          tailData_d = '0;
          tailErr_d  = 1'b0;
          count_d    = ONE;
        end
      end
      default: begin
        count_d    = EMPTY;
        headData_d = '0;
        headErr_d  = 1'b0;
        tailData_d = '0;
        tailErr_d  = 1'b0;
      end
    endcase
  end

  // A clear wins over the old value but still records an errored push in the same cycle.
  always_comb begin
    errCnt_d = errCnt_q;
    if (clr_err) begin
      errCnt_d = errPush ? CNT_W'(1) : '0;
    end else if (errPush && (errCnt_q != {CNT_W{1'b1}})) begin
      errCnt_d = errCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= EMPTY;
      headData_q <= '0;
      headErr_q  <= 1'b0;
      tailData_q <= '0;
      tailErr_q  <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      count_q    <= count_d;
      headData_q <= headData_d;
      headErr_q  <= headErr_d;
      tailData_q <= tailData_d;
      tailErr_q  <= tailErr_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign out_data = headData_q;
  assign out_err  = headErr_q;
  assign err_cnt  = errCnt_q;

endmodule

// File: tb/tb_bin_oh_codec.sv
// Self-checking bench for bin_oh_codec: a reference model feeds a scoreboard queue
// on every accepted push, and results are compared in order as the DUT pops them.
module tb_bin_oh_codec;

  localparam int Bin_w = 4;
  localparam int O_w   = 16;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [O_w-1:0] data;
    logic           err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [O_w-1:0]   in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [O_w-1:0]   out_data;
  logic             out_err;
  logic             clr_err = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int               checks = 0;
  int               errors = 0;
  res_t             sbq[$];
  res_t             pushRes;
  res_t             expRes;
  logic             errPush;
  logic [CNT_W-1:0] modelCnt = '0;

  bin_oh_codec #(
    .Bin_w(Bin_w),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .clr_err  (clr_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic mode, input logic [O_w-1:0] d);
    res_t r;
    r.data = '0;
    r.err  = 1'b0;
    if (!mode) begin
      if (d[O_w-1:Bin_w] != '0) r.err = 1'b1;
      else r.data[d[Bin_w-1:0]] = 1'b1;
    end else begin
      if ($countones(d) != 1) r.err = 1'b1;
      else for (int k = 0; k < O_w; k++) if (d[k]) r.data = O_w'(k);
    end
    return r;
  endfunction

  // Capture accepted pushes and the expected error count at the active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      modelCnt = '0;
    end else begin
      errPush = 1'b0;
      if (in_valid && in_ready) begin
        pushRes = model(in_mode, in_data);
        sbq.push_back(pushRes);
        errPush = pushRes.err;
      end
      if (clr_err) modelCnt = errPush ? CNT_W'(1) : '0;
      else if (errPush && modelCnt != '1) modelCnt = modelCnt + CNT_W'(1);
    end
  end

  // Pop and compare whenever the head will be consumed at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (err_cnt !== modelCnt) begin
        errors++;
        $display("[TB] FAIL err_cnt_track got %0d want %0d", err_cnt, modelCnt);
      end
      if (out_valid) begin
        if (out_ready) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected got %h/%b want no output", out_data, out_err);
          end else begin
            expRes = sbq.pop_front();
            if ({out_data, out_err} !== {expRes.data, expRes.err}) begin
              errors++;
              $display("[TB] FAIL sb_result got %h/%b want %h/%b",
                       out_data, out_err, expRes.data, expRes.err);
            end
          end
        end
      end else begin
        checks++;
        if (out_data !== '0 || out_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL idle_zero got %h/%b want 0000/0", out_data, out_err);
        end
      end
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== '0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got v=%b r=%b cnt=%0d d=%h want v=0 r=1 cnt=0 d=0000",
               out_valid, in_ready, err_cnt, out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_bin2oh();
    logic [O_w-1:0]   vin [4] = '{16'h0005, 16'h000F, 16'h0000, 16'h0013};
    logic [O_w-1:0]   vexp[4] = '{16'h0020, 16'h8000, 16'h0001, 16'h0000};
    logic             verr[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [CNT_W-1:0] vcnt[4] = '{3'd0, 3'd0, 3'd0, 3'd1};
    out_ready = 1'b1;
    in_mode   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data  = vin[i];
      in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[i] || out_err !== verr[i] || err_cnt !== vcnt[i]) begin
        errors++;
        $display("[TB] FAIL bin2oh_%h got v=%b d=%h e=%b cnt=%0d want v=1 d=%h e=%b cnt=%0d",
                 vin[i], out_valid, out_data, out_err, err_cnt, vexp[i], verr[i], vcnt[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_oh2bin();
    logic [O_w-1:0]   vin [5] = '{16'h0400, 16'h0001, 16'h8000, 16'h0000, 16'h0003};
    logic [O_w-1:0]   vexp[5] = '{16'h000A, 16'h0000, 16'h000F, 16'h0000, 16'h0000};
    logic             verr[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [CNT_W-1:0] vcnt[5] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
    out_ready = 1'b1;
    in_mode   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data  = vin[i];
      in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[i] || out_err !== verr[i] || err_cnt !== vcnt[i]) begin
        errors++;
        $display("[TB] FAIL oh2bin_%h got v=%b d=%h e=%b cnt=%0d want v=1 d=%h e=%b cnt=%0d",
                 vin[i], out_valid, out_data, out_err, err_cnt, vexp[i], verr[i], vcnt[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_mode   = 1'b0;
    in_data   = 16'h0001;
    in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_accept_a got ready=%b want 1", in_ready);
    end
    @(posedge clk); #1 in_data = 16'h0002;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL bp_accept_b got r=%b v=%b d=%h want r=1 v=1 d=0002", in_ready, out_valid, out_data);
    end
    @(posedge clk); #1 in_data = 16'h0003;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0002) begin
        errors++;
        $display("[TB] FAIL bp_stall got r=%b v=%b d=%h want r=0 v=1 d=0002", in_ready, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_data !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL bp_release got r=%b d=%h want r=0 d=0002", in_ready, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_data !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL bp_reopen got r=%b d=%h want r=1 d=0004", in_ready, out_data);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL bp_third got v=%b d=%h want v=1 d=0008", out_valid, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain got v=%b want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [O_w-1:0] expStream;
    out_ready = 1'b1;
    in_mode   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data  = O_w'(i);
      in_valid = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        expStream = 16'h0001 << (i - 1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== expStream) begin
          errors++;
          $display("[TB] FAIL stream_%0d got r=%b v=%b d=%h want r=1 v=1 d=%h",
                   i, in_ready, out_valid, out_data, expStream);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL stream_last got v=%b d=%h want v=1 d=8000", out_valid, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err_counter();
    out_ready = 1'b1;
    in_mode   = 1'b0;
    in_data   = 16'h0010;
    clr_err   = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    in_valid = 1'b1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_cnt !== 3'd7) begin
      errors++;
      $display("[TB] FAIL cnt_saturate got %0d want 7", err_cnt);
    end
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (err_cnt !== 3'd0) begin
      errors++;
      $display("[TB] FAIL cnt_clear got %0d want 0", err_cnt);
    end
    @(posedge clk); #1;
    clr_err  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clr_err  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_cnt !== 3'd1) begin
      errors++;
      $display("[TB] FAIL cnt_clear_with_err got %0d want 1", err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0013;
    @(posedge clk); #1 in_data = 16'h0004;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_prefill got r=%b v=%b want r=0 v=1", in_ready, out_valid);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    sbq.delete();
    modelCnt = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== '0 || out_data !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_async got v=%b r=%b cnt=%0d d=%h e=%b want v=0 r=1 cnt=0 d=0000 e=0",
               out_valid, in_ready, err_cnt, out_data, out_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_data   = 16'h0003;
    in_valid  = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0008 || out_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_first_push got v=%b d=%h e=%b want v=1 d=0008 e=0", out_valid, out_data, out_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_bin2oh();
    test_oh2bin();
    test_backpressure();
    test_back_to_back();
    test_err_counter();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
